// File: rtl/stream_demultiplexer.sv
// rtl/stream_demultiplexer.sv - 1-to-NOUT valid/ready stream demultiplexer with per-channel holding registers
// Destination is the explicit address or an internal round-robin pointer.
module stream_demultiplexer #(
  parameter int WIDTH  = 8,
  parameter int NOUT   = 4,
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rr_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [ADDR_W-1:0]       in_addr,
  output logic [NOUT-1:0]         out_valid,
  input  logic [NOUT-1:0]         out_ready,
  output logic [NOUT*WIDTH-1:0]   out_data,
  output logic                    addr_err,
  output logic [ADDR_W-1:0]       rr_ptr
);

  localparam logic [ADDR_W:0]   NOUT_EXT = (ADDR_W+1)'(NOUT);
  localparam logic [ADDR_W-1:0] RR_LAST  = ADDR_W'(NOUT - 1);

  logic [NOUT-1:0]   valid_q;
  logic [WIDTH-1:0]  data_q [NOUT];
  logic [ADDR_W-1:0] rr_q;
  logic              err_q;

  logic [ADDR_W-1:0] dest;
  logic              in_range;
  logic [NOUT-1:0]   sel;
  logic [NOUT-1:0]   load;
  logic              accept;

  always_comb begin
    dest     = rr_mode ? rr_q : in_addr;
    in_range = ({1'b0, dest} < NOUT_EXT);
    sel      = '0;
    for (int k = 0; k < NOUT; k++) begin
      sel[k] = in_range && (dest == ADDR_W'(k));
    end
  end

  // Out-of-range words are always accepted so they can be discarded without stalling.
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < NOUT; k++) begin
      if (sel[k]) begin
        in_ready = !valid_q[k] || out_ready[k];
      end
    end
  end

  assign accept = in_valid && in_ready;
  assign load   = accept ? sel : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < NOUT; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      // A load wins over a drain on the same channel, so a draining channel refills without a bubble.
      for (int k = 0; k < NOUT; k++) begin
        if (load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      err_q <= accept && !in_range;
      if (accept && rr_mode) begin
        rr_q <= (rr_q == RR_LAST) ? '0 : rr_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NOUT; k++) begin
      out_data[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  assign out_valid = valid_q;
  assign addr_err  = err_q;
  assign rr_ptr    = rr_q;

endmodule

// File: tb/tb_stream_demultiplexer.sv
// tb/tb_stream_demultiplexer.sv - directed table-driven bench for stream_demultiplexer
// A four-channel instance runs the vector table; a three-channel instance covers out-of-range and odd wrap.
module tb_stream_demultiplexer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rr_mode, in_valid, in_ready, addr_err;
  logic [7:0]  in_data;
  logic [1:0]  in_addr, rr_ptr;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;

  logic        reset3, rr_mode3, in_valid3, in_ready3, addr_err3;
  logic [7:0]  in_data3;
  logic [1:0]  in_addr3, rr_ptr3;
  logic [2:0]  out_valid3, out_ready3;
  logic [23:0] out_data3;

  stream_demultiplexer #(.WIDTH(8), .NOUT(4), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .rr_mode(rr_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .addr_err(addr_err), .rr_ptr(rr_ptr)
  );

  stream_demultiplexer #(.WIDTH(8), .NOUT(3), .ADDR_W(2)) dut3 (
    .clk(clk), .reset(reset3), .rr_mode(rr_mode3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_addr(in_addr3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3), .addr_err(addr_err3), .rr_ptr(rr_ptr3)
  );

  typedef struct {
    logic        rr;
    logic        v;
    logic [7:0]  d;
    logic [1:0]  a;
    logic [3:0]  rdy;
    logic        exp_ir;
    logic [3:0]  exp_v;
    logic [31:0] exp_d;
    logic [1:0]  exp_rr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(logic rr, logic v, logic [7:0] d, logic [1:0] a, logic [3:0] rdy,
                              logic ir, logic [3:0] ev, logic [31:0] ed, logic [1:0] err_rr, logic ee);
    vec_t t;
    t.rr = rr; t.v = v; t.d = d; t.a = a; t.rdy = rdy;
    t.exp_ir = ir; t.exp_v = ev; t.exp_d = ed; t.exp_rr = err_rr; t.exp_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rr_mode = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0; out_ready = '0;
    reset3 = 1'b1; rr_mode3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; in_addr3 = '0; out_ready3 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; reset3 = 1'b0;

    // reset then idle
    repeat (3) vecs.push_back(mk(0, 0, 8'h00, 2'd0, 4'b0000, 1, 4'b0000, 32'h00000000, 2'd0, 0));
    // addressed routing
    vecs.push_back(mk(0, 1, 8'hA1, 2'd2, 4'b1111, 1, 4'b0100, 32'h00A10000, 2'd0, 0));
    vecs.push_back(mk(0, 1, 8'hB2, 2'd0, 4'b1111, 1, 4'b0001, 32'h00A100B2, 2'd0, 0));
    vecs.push_back(mk(0, 1, 8'hC3, 2'd3, 4'b1111, 1, 4'b1000, 32'hC3A100B2, 2'd0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd0, 4'b1111, 1, 4'b0000, 32'hC3A100B2, 2'd0, 0));
    // backpressure and pass-through on channel 1
    vecs.push_back(mk(0, 1, 8'h11, 2'd1, 4'b1101, 1, 4'b0010, 32'hC3A111B2, 2'd0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 2'd1, 4'b1101, 0, 4'b0010, 32'hC3A111B2, 2'd0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 2'd1, 4'b1111, 1, 4'b0010, 32'hC3A122B2, 2'd0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd0, 4'b1111, 1, 4'b0000, 32'hC3A122B2, 2'd0, 0));
    // round-robin wrap
    vecs.push_back(mk(1, 1, 8'h00, 2'd0, 4'b1111, 1, 4'b0001, 32'hC3A12200, 2'd1, 0));
    vecs.push_back(mk(1, 1, 8'h01, 2'd0, 4'b1111, 1, 4'b0010, 32'hC3A10100, 2'd2, 0));
    vecs.push_back(mk(1, 1, 8'h02, 2'd0, 4'b1111, 1, 4'b0100, 32'hC3020100, 2'd3, 0));
    vecs.push_back(mk(1, 1, 8'h03, 2'd0, 4'b1111, 1, 4'b1000, 32'h03020100, 2'd0, 0));
    vecs.push_back(mk(1, 1, 8'h04, 2'd0, 4'b1111, 1, 4'b0001, 32'h03020104, 2'd1, 0));
    vecs.push_back(mk(1, 1, 8'h05, 2'd0, 4'b1111, 1, 4'b0010, 32'h03020504, 2'd2, 0));
    // fill channel 2 by address; rr pointer must hold across the mode toggle
    vecs.push_back(mk(0, 1, 8'h77, 2'd2, 4'b1011, 1, 4'b0100, 32'h03770504, 2'd2, 0));
    // rr target full and not draining: stall, pointer does not skip
    vecs.push_back(mk(1, 1, 8'h88, 2'd0, 4'b1011, 0, 4'b0100, 32'h03770504, 2'd2, 0));
    vecs.push_back(mk(1, 1, 8'h88, 2'd0, 4'b1011, 0, 4'b0100, 32'h03770504, 2'd2, 0));
    // setup for reset mid-operation: channels 0 and 2 full, rr_ptr = 3
    vecs.push_back(mk(0, 1, 8'h90, 2'd0, 4'b1010, 1, 4'b0101, 32'h03770590, 2'd2, 0));
    vecs.push_back(mk(1, 1, 8'hAA, 2'd0, 4'b1110, 1, 4'b0101, 32'h03AA0590, 2'd3, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rr_mode = vecs[i].rr; in_valid = vecs[i].v; in_data = vecs[i].d;
      in_addr = vecs[i].a; out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_v));
      chk($sformatf("v%0d out_data", i), out_data, vecs[i].exp_d);
      chk($sformatf("v%0d rr_ptr", i), 32'(rr_ptr), 32'(vecs[i].exp_rr));
      chk($sformatf("v%0d addr_err", i), 32'(addr_err), 32'(vecs[i].exp_err));
    end

    // reset coinciding with an accept into empty channel 3
    reset = 1'b1; rr_mode = 1'b1; in_valid = 1'b1; in_data = 8'hBB; out_ready = 4'b1010;
    #1;
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset out_data", out_data, 32'd0);
    chk("midreset rr_ptr", 32'(rr_ptr), 32'd0);
    chk("midreset addr_err", 32'(addr_err), 32'd0);

    // NOUT=3: fill channel 0, then discard a word addressed to 3
    in_valid3 = 1'b1; in_data3 = 8'h20; in_addr3 = 2'd0; out_ready3 = 3'b000;
    @(posedge clk);
    #1;
    chk("n3 load out_valid", 32'(out_valid3), 32'b001);
    chk("n3 load addr_err", 32'(addr_err3), 32'd0);
    in_data3 = 8'h55; in_addr3 = 2'd3;
    #1;
    chk("n3 oor in_ready", 32'(in_ready3), 32'd1);
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    chk("n3 oor addr_err", 32'(addr_err3), 32'd1);
    chk("n3 oor out_valid", 32'(out_valid3), 32'b001);
    chk("n3 oor out_data", 32'(out_data3), 32'h000020);
    @(posedge clk);
    #1;
    chk("n3 err one-shot", 32'(addr_err3), 32'd0);

    // NOUT=3 round-robin wrap 2 -> 0
    rr_mode3 = 1'b1; in_valid3 = 1'b1; out_ready3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      in_data3 = 8'(8'h30 + i);
      @(posedge clk);
      #1;
      chk($sformatf("n3 rr%0d rr_ptr", i), 32'(rr_ptr3), 32'((i + 1) % 3));
      chk($sformatf("n3 rr%0d out_valid", i), 32'(out_valid3), 32'(3'b001 << (i % 3)));
    end
    in_valid3 = 1'b0;
    chk("n3 rr out_data", 32'(out_data3), 32'h323133);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
